// File: rtl/bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder
//   Multi-digit packed-BCD adder/subtractor that handles one decimal digit per
//   clock, least-significant digit first. Subtraction uses the ten's
//   complement: each B digit is replaced by its nine's complement and the
//   initial carry is the inverted borrow-in.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, accepted only while ready=1
//   Mode   in   0 = A+B+Cin, 1 = A-B-Cin (Cin is the borrow-in)
//   A, B   in   packed BCD operands, digit 0 in [3:0]
//   Cin    in   carry-in / borrow-in
//   ready  out  high in IDLE only
//   done   out  one-cycle pulse; Sum/Cout/Err are valid
//   Sum    out  packed BCD result (ten's complement if a subtraction is negative)
//   Cout   out  add: decimal carry-out; subtract: 1 = no borrow
//   Err    out  an operand digit latched at start was greater than 9
// ---------------------------------------------------------------------------
module bcd_serial_adder #(
  parameter  int unsigned DIGITS = 4,
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                Mode,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Cin,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] Sum,
  output logic                Cout,
  output logic                Err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] a_q, a_d;
  logic [4*DIGITS-1:0] b_q, b_d;
  logic                mode_q, mode_d;
  logic [4*DIGITS-1:0] sum_q, sum_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Digit currently addressed by the counter.
  logic [3:0] a_dig, b_dig, b_eff, dig_res;
  logic [4:0] dig_sum;
  logic       dig_carry;
  logic       last_dig;

  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // Nine's complement wraps in 4 bits so invalid B nibbles still yield a value.
  always_comb begin
    b_eff   = mode_q ? (4'd9 - b_dig) : b_dig;
    dig_sum = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
    if (dig_sum > 5'd9) begin
      dig_res   = dig_sum[3:0] + 4'd6;
      dig_carry = 1'b1;
    end else begin
      dig_res   = dig_sum[3:0];
      dig_carry = 1'b0;
    end
  end

  assign last_dig = (cnt_q == CNT_W'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          mode_d  = Mode;
          sum_d   = '0;
          err_d   = has_bad_digit(A) | has_bad_digit(B);
          carry_d = Mode ? ~Cin : Cin;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) sum_d[4*i +: 4] = dig_res;
        end
        carry_d = dig_carry;
        cnt_d   = cnt_q + 1'b1;
        if (last_dig) begin
          cout_d  = dig_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign Sum   = sum_q;
  assign Cout  = cout_q;
  assign Err   = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_adder
//   Directed bench for bcd_serial_adder with DIGITS=4. Inputs are driven on
//   the falling clock edge and outputs sampled there, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_bcd_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        Mode;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        ready;
  logic        done;
  logic [15:0] Sum;
  logic        Cout;
  logic        Err;

  int vectors    = 0;
  int miscompares = 0;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Mode  (Mode),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .ready (ready),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Err   (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation. Operands are scrambled right after acceptance; if
  // intf>0 a competing start is pulsed in that CALC cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic c, input logic [15:0] es,
                        input logic ec, input logic ee, input int intf);
    int  k;
    bit  seen;
    @(negedge clk);
    A = a; B = b; Mode = m; Cin = c; start = 1'b1;
    @(posedge clk);
    k = 0;
    seen = 0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        A = 16'h5555; B = 16'h4444; Mode = ~m; Cin = ~c;
        check({tag, " ready_calc"}, {31'd0, ready}, 32'd0);
      end
      start = (intf > 0 && k == intf) ? 1'b1 : 1'b0;
      if (start) begin
        A = 16'h2222; B = 16'h3333; Mode = 1'b1; Cin = 1'b1;
      end
      if (done) seen = 1;
    end
    check({tag, " latency"}, k, 32'd5);
    check({tag, " sum"},   {16'd0, Sum},  {16'd0, es});
    check({tag, " cout"},  {31'd0, Cout}, {31'd0, ec});
    check({tag, " err"},   {31'd0, Err},  {31'd0, ee});
    check({tag, " ready_done"}, {31'd0, ready}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    check({tag, " done_clr"}, {31'd0, done}, 32'd0);
    check({tag, " ready_idle"}, {31'd0, ready}, 32'd1);
    check({tag, " sum_hold"}, {16'd0, Sum}, {16'd0, es});
  endtask

  initial begin
    int t1, t2, ndone;
    rst_n = 1'b0; start = 1'b0; Mode = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #12;
    check("rst sum",   {16'd0, Sum},  32'd0);
    check("rst cout",  {31'd0, Cout}, 32'd0);
    check("rst err",   {31'd0, Err},  32'd0);
    check("rst ready", {31'd0, ready}, 32'd1);
    check("rst done",  {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_chain", 16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add_max",   16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add_45_38", 16'h0045, 16'h0038, 1'b0, 1'b0, 16'h0083, 1'b0, 1'b0, 0);
    run_op("sub_pos",   16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0, 0);
    run_op("sub_neg",   16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0, 0);
    run_op("sub_bin",   16'h0100, 16'h0099, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    run_op("invalid",   16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1, 0);
    run_op("err_clear", 16'h0045, 16'h0038, 1'b0, 1'b0, 16'h0083, 1'b0, 1'b0, 0);
    run_op("ignored",   16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2);

    // start held high: done pulses should be DIGITS+2 cycles apart.
    @(negedge clk);
    A = 16'h0045; B = 16'h0038; Mode = 1'b0; Cin = 1'b0; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int cyc = 0; cyc < 30 && t2 < 0; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) t1 = cyc; else t2 = cyc;
      end
    end
    check("b2b interval", t2 - t1, 32'd6);
    check("b2b sum", {16'd0, Sum}, 32'h0083);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b idle", {31'd0, ready}, 32'd1);

    // Reset in the second CALC cycle of an operation that latched Err=1.
    run_op("pre_rst", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    @(negedge clk);
    A = 16'h00A0; B = 16'h0001; Mode = 1'b0; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("pre_rst err", {31'd0, Err}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst sum",   {16'd0, Sum},  32'd0);
    check("midrst cout",  {31'd0, Cout}, 32'd0);
    check("midrst err",   {31'd0, Err},  32'd0);
    check("midrst ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst no_done", ndone, 32'd0);
    run_op("post_rst", 16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Multi-digit packed-BCD adder/subtractor; processes one decimal digit per clock, least-significant digit first.
- Generalises the single-digit BCD adder to DIGITS digits and adds a subtract mode (ten's complement), invalid-digit detection and a start/done handshake.
- Sits in the arithmetic library as the area-lean alternative to a fully combinational multi-digit ripple of single-digit BCD adders.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS.
- CNT_W, $clog2(DIGITS+1), width of the internal digit counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when start=1 and ready=1.
- Mode  input  1  0 = add (A+B+Cin), 1 = subtract (A-B-Cin, Cin acts as borrow-in).
- A  input  4*DIGITS  packed BCD operand, digit 0 in [3:0].
- B  input  4*DIGITS  packed BCD operand.
- Cin  input  1  carry-in (add) or borrow-in (subtract).
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse: Sum, Cout and Err are valid.
- Sum  output  4*DIGITS  packed BCD result; ten's complement when the subtract result is negative.
- Cout  output  1  add: decimal carry-out. Subtract: 1 = no borrow (result >= 0), 0 = negative.
- Err  output  1  at least one latched operand digit was >9.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; ready=1; done=0; Sum=0; Cout=0; Err=0; counter=0; operand registers=0. Reset mid-operation aborts the operation, and no done pulse is issued.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - On start=1, latch A, B and Mode, clear Sum, set Err = OR over all digits (A_i>9 or B_i>9), set carry = Mode ? ~Cin : Cin, set counter=0, and go to CALC.
- CALC (exactly DIGITS cycles, ready=0):
  - Per cycle, digit i = counter: a = A_i; b = Mode ? (9 - B_i) mod 16 : B_i.
  - s = a + b + carry (5-bit). If s>9: digit = (s+6) mod 16, carry = 1. Otherwise digit = s, carry = 0.
  - Write the digit into Sum[4i+3:4i] and increment the counter.
  - When counter = DIGITS-1, the same edge moves to DONE.
- DONE (one cycle):
  - done=1 and Cout = final carry; return to IDLE on the next edge.
- Latency: start sampled at edge t; done is high during the cycle following edge t+DIGITS. Throughput is one operation per DIGITS+2 cycles.
- Sum, Cout and Err hold their values after done until the next accepted start. Sum digits are updated progressively during CALC; only the values present during done are meaningful.
- start while ready=0 (CALC or DONE) is ignored and not queued. A, B, Mode and Cin changes after acceptance have no effect.
- Invalid digits do not stop the operation; the result is computed from the raw nibbles and Err=1 flags it.
- Wrap-around: the add result is mod 10^DIGITS, with overflow reported only via Cout.
- DIGITS=1 is legal: CALC lasts 1 cycle.
- No combinational path from inputs to outputs.

Test Plan (DIGITS=4):
- Add with carry chain: A=0x1234, B=0x8766, Cin=0, Mode=0 -> done exactly 5 cycles after the start edge, Sum=0x0000, Cout=1, Err=0.
- Add with Cin at max: A=0x9999, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1. Separately, A=0x0045, B=0x0038, Cin=0 -> Sum=0x0083, Cout=0.
- Subtract positive and negative:
  - 0x0500-0x0123, Cin=0 -> Sum=0x0377, Cout=1.
  - 0x0123-0x0500 -> Sum=0x9623, Cout=0.
  - 0x0100-0x0099, Cin=1 -> Sum=0x0000, Cout=1.
- Invalid digit: A=0x00A0, B=0x0001 -> Err=1 at done, and the operation still completes. A following valid start clears Err to 0.
- Handshake:
  - Pulse start again during CALC with different operands -> ignored, and the first result is unchanged.
  - start held high continuously -> back-to-back operations every 6 cycles.
  - ready is low from the accept edge until the return to IDLE.
- Reset mid-op: assert rst_n=0 asynchronously in the 2nd CALC cycle -> Sum=0, Cout=0, Err=0, ready=1 immediately. No done pulse follows, and the next operation runs correctly.
